// File: rtl/adc_channel_scheduler_if.sv
// Output stream from the ADC channel scheduler to
// the phased-delay datapath (valid/ready).
interface adc_channel_scheduler_if;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sample;
  logic [3:0] out_channel;

  modport master (
    output out_valid,
    output out_sample,
    output out_channel,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_sample,
    input  out_channel,
    output out_ready
  );
endinterface

// File: rtl/adc_channel_scheduler.sv
// Round-robin ADC channel scheduler: select, settle,
// capture the first matching conversion, present it.
module adc_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [3:0]        channel,
  input  logic              new_sample,
  input  logic [9:0]        sample,
  input  logic [3:0]        sample_channel,
  adc_channel_scheduler_if.master out_if,
  output logic              sweep_done,
  output logic              timeout_err,
  input  logic              clear_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, WAIT, PRESENT
  } state_t;

  localparam logic [7:0] ST_LOAD =
    8'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nx;
  logic [NUM_CH-1:0] mask_q;
  logic [3:0]        cur;
  logic [7:0]        st_cnt;
  logic [15:0]       tmo_cnt;
  logic              valid_q;
  logic [9:0]        osmp_q;
  logic [3:0]        och_q;

  logic [3:0] lo_idx, nxt_idx;
  logic       has_nxt;
  logic       restart, match, timeout, hs, done;
  logic       load, advance, capture;

  assign out_if.out_valid   = valid_q;
  assign out_if.out_sample  = osmp_q;
  assign out_if.out_channel = och_q;

  assign restart = enable && (ch_mask != '0);
  assign match   = new_sample
                && (sample_channel == channel);
  assign timeout = (state == WAIT) && !match
                && (tmo_cnt == TMO_LAST);
  assign hs      = (state == PRESENT) && valid_q
                && out_if.out_ready;
  assign done    = hs || timeout;

  // lowest bit of the new mask, next bit above cur
  always_comb begin
    lo_idx  = '0;
    nxt_idx = '0;
    has_nxt = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) lo_idx = 4'(i);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) > cur)) begin
        nxt_idx = 4'(i);
        has_nxt = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (restart) state_nx = SELECT;
      SELECT:
        state_nx = (SETTLE_CYCLES == 0) ? WAIT
                                        : SETTLE;
      SETTLE:
        if (st_cnt == '0) state_nx = WAIT;
      WAIT:
        if (match) state_nx = PRESENT;
      PRESENT: ;
      default: state_nx = IDLE;
    endcase
    if (done) begin
      if (has_nxt)
        state_nx = enable ? SELECT : IDLE;
      else
        state_nx = restart ? SELECT : IDLE;
    end
  end

  // FSM outputs and datapath strobes
  always_comb begin
    busy       = (state != IDLE);
    sweep_done = done && !has_nxt;
    capture    = (state == WAIT) && match;
    advance    = done && has_nxt && enable;
    load       = ((state == IDLE) && restart)
              || (done && !has_nxt && restart);
  end

  // mask latch, counters, captured sample, error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q      <= '0;
      cur         <= '0;
      channel     <= '0;
      st_cnt      <= '0;
      tmo_cnt     <= '0;
      valid_q     <= 1'b0;
      osmp_q      <= '0;
      och_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load) begin
        mask_q <= ch_mask;
        cur    <= lo_idx;
      end else if (advance) begin
        cur <= nxt_idx;
      end
      if (state == SELECT) begin
        channel <= cur;
        st_cnt  <= ST_LOAD;
      end else if ((state == SETTLE)
                && (st_cnt != '0)) begin
        st_cnt <= st_cnt - 8'd1;
      end
      if (state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
      else               tmo_cnt <= '0;
      if (capture) begin
        valid_q <= 1'b1;
        osmp_q  <= sample;
        och_q   <= channel;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
      if (timeout)        timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler: cycle
// table for a full sweep plus corner sequences.
module tb_adc_channel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] ch_mask;
  logic [3:0] channel;
  logic       new_sample;
  logic [9:0] sample;
  logic [3:0] sample_channel;
  logic       sweep_done;
  logic       timeout_err;
  logic       clear_err;
  logic       busy;

  adc_channel_scheduler_if ifc ();

  adc_channel_scheduler #(
    .NUM_CH(4),
    .SETTLE_CYCLES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .ch_mask(ch_mask),
    .channel(channel),
    .new_sample(new_sample),
    .sample(sample),
    .sample_channel(sample_channel),
    .out_if(ifc),
    .sweep_done(sweep_done),
    .timeout_err(timeout_err),
    .clear_err(clear_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  mask;
    logic        ns;
    logic [3:0]  sch;
    logic [9:0]  smp;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t        tbl [24];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        echo = 1'b0;
  logic [15:0] echo_mask = 16'hFFFF;

  function automatic logic [21:0] ex(
    input logic v, input logic [3:0] oc,
    input logic [9:0] os, input logic sd,
    input logic b, input logic [3:0] ch,
    input logic te);
    return {v, oc, os, sd, b, ch, te};
  endfunction

  function automatic vec_t mk(
    input logic en, input logic [3:0] m,
    input logic ns, input logic [3:0] sch,
    input logic [9:0] smp, input logic rdy,
    input logic [21:0] e);
    vec_t r;
    r.en = en; r.mask = m; r.ns = ns;
    r.sch = sch; r.smp = smp; r.rdy = rdy;
    r.exp = e;
    return r;
  endfunction

  function automatic logic [21:0] outs();
    return {ifc.out_valid, ifc.out_channel,
            ifc.out_sample, sweep_done, busy,
            channel, timeout_err};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (echo) begin
      new_sample     = echo_mask[channel];
      sample_channel = channel;
      sample         = 10'(100 + int'(channel));
    end else begin
      new_sample = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0; ch_mask = '0;
    new_sample = 1'b0; sample = '0;
    sample_channel = '0; clear_err = 1'b0;
    ifc.out_ready = 1'b0;
    echo = 1'b0; echo_mask = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!ifc.out_valid && n < 64) begin
      tick();
      n++;
    end
    chk(nm, 32'(ifc.out_valid), 1);
  endtask

  initial begin
    tbl[0]  = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 0, 0, 0, 0, 0, 0));
    tbl[1]  = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 0, 0, 0, 1, 0, 0));
    tbl[2]  = mk(1, 4'hB, 1, 0, 55, 1,
                 ex(0, 0, 0, 0, 1, 0, 0));
    tbl[3]  = mk(1, 4'hB, 1, 0, 56, 1,
                 ex(0, 0, 0, 0, 1, 0, 0));
    tbl[4]  = mk(1, 4'hB, 1, 0, 100, 1,
                 ex(0, 0, 0, 0, 1, 0, 0));
    tbl[5]  = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(1, 0, 100, 0, 1, 0, 0));
    tbl[6]  = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 0, 100, 0, 1, 0, 0));
    tbl[7]  = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 0, 100, 0, 1, 1, 0));
    tbl[8]  = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 0, 100, 0, 1, 1, 0));
    tbl[9]  = mk(1, 4'hB, 1, 2, 222, 1,
                 ex(0, 0, 100, 0, 1, 1, 0));
    tbl[10] = mk(1, 4'hB, 1, 1, 101, 0,
                 ex(0, 0, 100, 0, 1, 1, 0));
    tbl[11] = mk(1, 4'hB, 0, 0, 0, 0,
                 ex(1, 1, 101, 0, 1, 1, 0));
    tbl[12] = mk(1, 4'hB, 1, 1, 333, 0,
                 ex(1, 1, 101, 0, 1, 1, 0));
    tbl[13] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(1, 1, 101, 0, 1, 1, 0));
    tbl[14] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 1, 101, 0, 1, 1, 0));
    tbl[15] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 1, 101, 0, 1, 3, 0));
    tbl[16] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 1, 101, 0, 1, 3, 0));
    tbl[17] = mk(1, 4'hB, 1, 3, 103, 1,
                 ex(0, 1, 101, 0, 1, 3, 0));
    tbl[18] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(1, 3, 103, 1, 1, 3, 0));
    tbl[19] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 3, 103, 0, 1, 3, 0));
    tbl[20] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 3, 103, 0, 1, 0, 0));
    tbl[21] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(0, 3, 103, 0, 1, 0, 0));
    tbl[22] = mk(1, 4'hB, 1, 0, 100, 1,
                 ex(0, 3, 103, 0, 1, 0, 0));
    tbl[23] = mk(1, 4'hB, 0, 0, 0, 1,
                 ex(1, 0, 100, 0, 1, 0, 0));

    // sweep over mask 1011, cycle by cycle
    do_reset();
    for (int i = 0; i < 24; i++) begin
      enable         = tbl[i].en;
      ch_mask        = tbl[i].mask;
      new_sample     = tbl[i].ns;
      sample_channel = tbl[i].sch;
      sample         = tbl[i].smp;
      ifc.out_ready  = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d", i),
          32'(outs()), 32'(tbl[i].exp));
      @(negedge clk);
    end

    // back-pressure: hold out_ready low 20 cycles
    do_reset();
    enable = 1'b1; ch_mask = 4'b0001;
    echo = 1'b1;
    #1;
    wait_valid("hold_valid");
    echo = 1'b0; new_sample = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 3 == 0) begin
        new_sample = 1'b1;
        sample_channel = 4'd0;
        sample = 10'd500;
      end
      #1;
      chk($sformatf("hold%0d", i),
          32'({ifc.out_valid, ifc.out_channel,
               ifc.out_sample}),
          32'({1'b1, 4'd0, 10'd100}));
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("hold_single_sd", 32'(sweep_done), 1);
    tick();
    chk("hold_release",
        32'({ifc.out_valid, busy}), 32'(2'b01));

    // channel 1 never answers: timeout
    do_reset();
    enable = 1'b1; ch_mask = 4'b0011;
    ifc.out_ready = 1'b1;
    echo = 1'b1; echo_mask = 16'h0001;
    #1;
    begin
      int n = 0;
      while (channel != 4'd1 && n < 64) begin
        tick();
        n++;
      end
    end
    chk("tmo_reach_ch1", 32'(channel), 1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tmo_wait%0d", k),
          32'({ifc.out_valid, timeout_err,
               sweep_done}),
          32'({1'b0, 1'b0, (k == 9)}));
      tick();
    end
    chk("tmo_err_set", 32'(timeout_err), 1);
    enable = 1'b0;
    wait_valid("tmo_ch0_next");
    chk("tmo_ch0_val",
        32'({ifc.out_channel, ifc.out_sample,
             sweep_done}),
        32'({4'd0, 10'd100, 1'b0}));
    tick();
    chk("tmo_idle",
        32'({busy, timeout_err}), 32'(2'b01));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("tmo_clear", 32'(timeout_err), 0);

    // enable dropped in WAIT on channel 0
    do_reset();
    enable = 1'b1; ch_mask = 4'b0111;
    ifc.out_ready = 1'b1;
    #1;
    repeat (4) tick();
    chk("drop_in_wait",
        32'({busy, channel}), 32'({1'b1, 4'd0}));
    enable = 1'b0;
    new_sample = 1'b1;
    sample_channel = 4'd0;
    sample = 10'd100;
    tick();
    chk("drop_present",
        32'({ifc.out_valid, ifc.out_channel,
             ifc.out_sample, sweep_done}),
        32'({1'b1, 4'd0, 10'd100, 1'b0}));
    tick();
    chk("drop_idle",
        32'({busy, ifc.out_valid, sweep_done}),
        32'(3'b000));
    tick();
    chk("drop_stay", 32'(busy), 0);

    // mask change mid-sweep
    do_reset();
    enable = 1'b1; ch_mask = 4'b0011;
    ifc.out_ready = 1'b1;
    echo = 1'b1;
    #1;
    wait_valid("msk_v0");
    chk("msk_c0", 32'(ifc.out_channel), 0);
    tick();
    ch_mask = 4'b0100;
    wait_valid("msk_v1");
    chk("msk_c1", 32'(ifc.out_channel), 1);
    tick();
    wait_valid("msk_v2");
    chk("msk_c2",
        32'({ifc.out_channel, ifc.out_sample}),
        32'({4'd2, 10'd102}));
    tick();
    wait_valid("msk_v3");
    chk("msk_c3", 32'(ifc.out_channel), 2);

    // async reset in PRESENT
    do_reset();
    enable = 1'b1; ch_mask = 4'b0100;
    echo = 1'b1;
    #1;
    wait_valid("rst_v");
    chk("rst_pre",
        32'({ifc.out_channel, ifc.out_sample}),
        32'({4'd2, 10'd102}));
    enable = 1'b0; echo = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'(outs()),
        32'(ex(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1'b1;
    #1;
    tick();
    chk("rst_idle",
        32'({busy, ifc.out_valid}), 32'(2'b00));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
